// File: rtl/uart_out_port.sv
// uart_out_port: small byte FIFO feeding a UART transmitter (8N1, idle-high line).
// Define UART_OUT_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_out_port #(
   parameter int unsigned CLKS_PER_BIT = 16,
   parameter int unsigned FIFO_DEPTH   = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [7:0] wr_data,
   input  logic       wr_en,
   output logic       full,
   output logic       empty,
   output logic       overflow,
   output logic       busy,
   output logic       tx
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = $clog2(CLKS_PER_BIT);

`ifdef UART_OUT_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

   state_t        state;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;
   logic [TW-1:0] timer;
   logic [2:0]    idx;
   logic [7:0]    shreg;
   logic          push_c;
   logic          pop_c;
   logic          bit_end_c;
   logic          idle_nxt_c;
`ifdef UART_OUT_PARITY_EN
   logic          par;
`endif

   // A pop happens only when the line is free to start a new frame: from IDLE or at the end of STOP.
   always_comb begin
      bit_end_c  = (timer == TW'(CLKS_PER_BIT - 1));
      push_c     = wr_en && !full;
      pop_c      = !empty && ((state == IDLE) || ((state == STOP) && bit_end_c));
      count_nxt  = count + CW'(push_c) - CW'(pop_c);
      idle_nxt_c = !pop_c && ((state == IDLE) || ((state == STOP) && bit_end_c));
   end

   always_ff @(posedge clk) begin
      if (push_c) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         tx       <= 1'b1;
         timer    <= '0;
         idx      <= '0;
         shreg    <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         full     <= 1'b0;
         empty    <= 1'b1;
         overflow <= 1'b0;
         busy     <= 1'b0;
`ifdef UART_OUT_PARITY_EN
         par      <= 1'b0;
`endif
      end else begin
         count <= count_nxt;
         full  <= (count_nxt == CW'(FIFO_DEPTH));
         empty <= (count_nxt == '0);
         busy  <= !idle_nxt_c || (count_nxt != '0);
         if (push_c) wr_ptr <= wr_ptr + 1'b1;
         if (pop_c) rd_ptr <= rd_ptr + 1'b1;
         if (wr_en && full) overflow <= 1'b1;

         if (pop_c) begin
            // Load the next byte and drive the start bit on this same edge.
            shreg <= mem[rd_ptr];
            tx    <= 1'b0;
            timer <= '0;
            state <= START;
`ifdef UART_OUT_PARITY_EN
            par   <= ^mem[rd_ptr];
`endif
         end else begin
            case (state)
               IDLE: tx <= 1'b1;
               START: begin
                  if (bit_end_c) begin
                     timer <= '0;
                     idx   <= '0;
                     tx    <= shreg[0];
                     state <= DATA;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               DATA: begin
                  if (bit_end_c) begin
                     timer <= '0;
                     shreg <= {1'b0, shreg[7:1]};
                     if (idx == 3'd7) begin
`ifdef UART_OUT_PARITY_EN
                        tx    <= par;
                        state <= PARITY;
`else
                        tx    <= 1'b1;
                        state <= STOP;
`endif
                     end else begin
                        idx <= idx + 1'b1;
                        tx  <= shreg[1];
                     end
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
`ifdef UART_OUT_PARITY_EN
               PARITY: begin
                  if (bit_end_c) begin
                     timer <= '0;
                     tx    <= 1'b1;
                     state <= STOP;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
`endif
               STOP: begin
                  if (bit_end_c) begin
                     timer <= '0;
                     state <= IDLE;
                  end else begin
                     timer <= timer + 1'b1;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule

// File: tb/tb_uart_out_port.sv
// tb_uart_out_port: randomized scoreboard bench for uart_out_port.
// The model derives frame start edges and FIFO occupancy from accepted writes alone.
`timescale 1ns/1ps
module tb_uart_out_port;
   localparam int CPB   = 4;
   localparam int DEPTH = 4;
   localparam int CPB2  = 2;
`ifdef UART_OUT_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME  = NBITS * CPB;
   localparam int FRAME2 = NBITS * CPB2;

   typedef struct {
      logic [7:0] data;
      int         start;
   } exp_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] wr_data = 8'h00;
   logic       wr_en = 1'b0;
   logic       full, empty, overflow, busy, tx;
   logic [7:0] wr_data2 = 8'h00;
   logic       wr_en2 = 1'b0;
   logic       full2, empty2, overflow2, busy2, tx2;

   int   checks = 0;
   int   errors = 0;
   int   n = 0;
   int   rst_count = 0;
   exp_t sb[$];
   int   pend[$];
   int   last_end = 0;
   logic ovf_m = 1'b0;

   always #5 clk = ~clk;

   uart_out_port #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .wr_data(wr_data), .wr_en(wr_en),
      .full(full), .empty(empty), .overflow(overflow), .busy(busy), .tx(tx));

   uart_out_port #(.CLKS_PER_BIT(CPB2), .FIFO_DEPTH(DEPTH)) dut2 (
      .clk(clk), .reset(reset), .wr_data(wr_data2), .wr_en(wr_en2),
      .full(full2), .empty(empty2), .overflow(overflow2), .busy(busy2), .tx(tx2));

   // Line level j cycles into a frame carrying byte d.
   function automatic logic exp_bit(input logic [7:0] d, input int j, input int cpb);
      int b;
      b = j / cpb;
      if (b == 0) return 1'b0;
      if (b <= 8) return d[b-1];
`ifdef UART_OUT_PARITY_EN
      if (b == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   task automatic chk(input string name, input int act, input int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("FAIL %s at edge %0d: got %0d expected %0d", name, n, act, expv);
      end
   endtask

   // Bytes still in the FIFO after edge n: accepted but not yet started.
   task automatic prune(output int o);
      while (pend.size() > 0 && pend[0] <= n) void'(pend.pop_front());
      o = pend.size();
   endtask

   task automatic step(input logic we, input logic [7:0] d);
      int   o;
      exp_t e;
      prune(o);
      wr_en   = we;
      wr_data = d;
      if (we) begin
         if (o == DEPTH) ovf_m = 1'b1;
         else begin
            e.data  = d;
            e.start = (n + 2 > last_end) ? n + 2 : last_end;
            last_end = e.start + FRAME;
            sb.push_back(e);
            pend.push_back(e.start);
         end
      end
      @(posedge clk);
      n++;
      #1;
      wr_en = 1'b0;
      prune(o);
      chk("empty", int'(empty), int'(o == 0));
      chk("full", int'(full), int'(o == DEPTH));
      chk("overflow", int'(overflow), int'(ovf_m));
      chk("busy", int'(busy), int'((o > 0) || (n < last_end)));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      wr_en = 1'b0;
      @(posedge clk);
      n++;
      #1;
      rst_count++;
      sb.delete();
      pend.delete();
      last_end = 0;
      ovf_m = 1'b0;
      chk("rst_tx", int'(tx), 1);
      chk("rst_empty", int'(empty), 1);
      chk("rst_full", int'(full), 0);
      chk("rst_overflow", int'(overflow), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_tx2", int'(tx2), 1);
      reset = 1'b0;
   endtask

   task automatic drain();
      int k;
      k = 0;
      while ((busy || sb.size() != 0) && k < 3000) begin
         step(1'b0, 8'h00);
         k++;
      end
      chk("drain_timeout", int'(k < 3000), 1);
      repeat (2) step(1'b0, 8'h00);
   endtask

   // Monitor: each falling edge of an idle line opens a frame, checked cycle by cycle.
   initial begin : monitor
      exp_t       e;
      int         rs;
      int         b;
      logic       bad;
      logic       have;
      logic [7:0] got;
      forever begin
         @(posedge clk);
         #2;
         if (!reset && tx == 1'b0) begin
            rs   = rst_count;
            bad  = 1'b0;
            got  = 8'h00;
            have = (sb.size() != 0);
            if (have) begin
               e = sb.pop_front();
               chk("frame_start", n, e.start);
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_frame at edge %0d", n);
            end
            for (int j = 1; j < FRAME; j++) begin
               @(posedge clk);
               #2;
               if (rst_count != rs) break;
               if (j % CPB == CPB / 2) begin
                  b = j / CPB;
                  if (b >= 1 && b <= 8) got[b-1] = tx;
               end
               if (have && tx !== exp_bit(e.data, j, CPB)) bad = 1'b1;
            end
            if (have && rst_count == rs) begin
               checks++;
               if (bad) begin
                  errors++;
                  $display("FAIL frame_data started edge %0d: got %02h expected %02h (or bad bit timing)",
                           e.start, got, e.data);
               end
            end
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : stimulus
      int   s;
      int   j;
      logic expb;
      int   probs[3];
      probs[0] = 5;
      probs[1] = 20;
      probs[2] = 60;

      do_reset();
      repeat (3) step(1'b0, 8'h00);

      // Single byte: latency, bit order, frame length.
      step(1'b1, 8'hA5);
      drain();

      // Burst past capacity, then keep writing so drops coincide with pops.
      for (int i = 1; i <= 6; i++) step(1'b1, 8'(i));
      for (int i = 0; i < 2 * FRAME; i++) step(1'b1, 8'($urandom));
      drain();

      // Parity-sensitive bytes.
      step(1'b1, 8'h07);
      drain();
      step(1'b1, 8'h03);
      drain();

      // Reset in the middle of data bit 3, then a clean frame.
      step(1'b1, 8'h55);
      s = n + 1;
      while (n < s + 4 * CPB + 1) step(1'b0, 8'h00);
      do_reset();
      step(1'b1, 8'h0F);
      drain();

      // Random traffic at several write densities.
      for (int p = 0; p < 3; p++) begin
         for (int i = 0; i < 400; i++)
            step(logic'($urandom_range(0, 99) < probs[p]), 8'($urandom));
         drain();
      end

      // Minimum divider on the second instance: 0xFF then 0x00 back-to-back.
      wr_en2   = 1'b1;
      wr_data2 = 8'hFF;
      step(1'b0, 8'h00);
      s = n + 1;
      wr_data2 = 8'h00;
      step(1'b0, 8'h00);
      wr_en2 = 1'b0;
      for (int k = 0; k < 2 * FRAME2 + 3; k++) begin
         j = n - s;
         if (j >= 0 && j < FRAME2) expb = exp_bit(8'hFF, j, CPB2);
         else if (j >= FRAME2 && j < 2 * FRAME2) expb = exp_bit(8'h00, j - FRAME2, CPB2);
         else expb = 1'b1;
         chk("tx2", int'(tx2), int'(expb));
         step(1'b0, 8'h00);
      end
      chk("busy2_idle", int'(busy2), 0);
      chk("empty2_idle", int'(empty2), 1);
      chk("overflow2", int'(overflow2), 0);
      chk("full2", int'(full2), 0);
      chk("scoreboard_empty", sb.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_out_port.md
Name: uart_out_port

Overview:
- Downstream output stage of the processor core; consumes bytes the core writes to its output port.
- Buffers writes in a small FIFO and serialises each byte as an 8N1 UART frame on a single pin.
- Lets a program stream text/results off-chip over one pin, leaving the remaining output pins free.
- Purely synchronous.

Parameters:
- CLKS_PER_BIT, 16: clock cycles per UART bit. Legal range 2..65535.
- FIFO_DEPTH, 4: FIFO entries. Must be a power of two, minimum 2.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- wr_data  input  8  byte from processor output port
- wr_en  input  1  write strobe, one byte per cycle it is high
- full  output  1  FIFO full (registered)
- empty  output  1  FIFO empty (registered)
- overflow  output  1  sticky: a write was dropped
- busy  output  1  high while a frame is on the line or the FIFO is non-empty
- tx  output  1  UART serial out, idle high

Behaviour:
Reset, applied synchronously on any edge with reset=1, including mid-frame:
- tx=1, full=0, empty=1, overflow=0, busy=0.
- FIFO pointers cleared; FSM returns to IDLE.
- The frame in progress is abandoned and tx returns high on that edge.

FIFO:
- Write accepted on an edge with wr_en=1 and full=0 as sampled before that edge.
- When full=1, the write is dropped even if a pop happens on the same edge, and overflow is set. overflow is cleared only by reset.
- Simultaneous accepted write and pop: occupancy unchanged; flags unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Occupancy counter is log2(FIFO_DEPTH)+1 bits wide.
- full = (count == FIFO_DEPTH); empty = (count == 0). Both registered and updated on the same edge as count.

FSM states: IDLE, START, DATA, STOP (plus PARITY, see Optional Feature).
- Bit timer counts 0..CLKS_PER_BIT-1; a bit ends when the timer reaches CLKS_PER_BIT-1.
- Bit index is 3 bits.
- IDLE, FIFO non-empty: pop the head into an 8-bit shift register, drive tx=0, go to START, timer=0.
- START end: tx=data[0], go to DATA, index=0.
- DATA: LSB first; at the end of each bit, shift. After bit 7 ends, go to STOP with tx=1.
- STOP end:
  - FIFO non-empty: pop and go to START directly. No idle cycle between frames; tx drops low on the same edge.
  - FIFO empty: go to IDLE.

Timing:
- Latency: write sampled on edge E into an empty FIFO with the FSM in IDLE → tx low after edge E+1 (empty is 0 by then).
- Frame length: 10*CLKS_PER_BIT cycles; each bit holds exactly CLKS_PER_BIT cycles.
- busy = (state != IDLE) || !empty. It is low only when the line is idle and nothing is queued.

Optional Feature:
Macro UART_OUT_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. It drives even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles. Frame is 8E1, 11*CLKS_PER_BIT cycles.
- Undefined: no PARITY state or logic; frame is 8N1, 10*CLKS_PER_BIT cycles.

Test Plan:
- CLKS_PER_BIT=4, write 0xA5 once → tx low 1 cycle after write, then each bit held 4 cycles: 0,1,0,1,0,0,1,0,1,1. busy falls 40 cycles after tx first goes low; empty=1, overflow=0.
- FIFO_DEPTH=4, 5 consecutive writes 0x01..0x05 with the FSM idle at start:
  - First byte is popped the cycle after its write, so 0x05 is accepted and full=1 afterwards.
  - A 6th write 0x06 → dropped, overflow=1.
  - tx emits 0x01..0x05 back-to-back with no idle cycle between the stop bit and the next start bit.
- Write while full with a pop on the same edge → write dropped, overflow=1, count decrements by 1.
- Assert reset during DATA bit 3 of 0x55 → after that edge tx=1, empty=1, busy=0. Next write 0x0F transmits a full clean frame.
- With UART_OUT_PARITY_EN and CLKS_PER_BIT=4, write 0x07 → parity bit 1, frame 44 cycles. Write 0x03 → parity bit 0.
- CLKS_PER_BIT=2, write 0xFF then 0x00 → correct frames with 2-cycle bits; the timer wraps correctly at the minimum divider.
